param_timer: RTL



---
 rtl/param_timer_pkg.sv | 19 +
 rtl/param_timer_tick_gen.sv | 33 +++
 rtl/param_timer.sv | 117 +++++++++++
 3 files changed

// File: rtl/param_timer_pkg.sv
// Shared definitions for the interval timer and its prescaler.
package param_timer_pkg;

  // Codes used to address the time-parameter store.
  localparam logic [1:0] T_ARM_DELAY       = 2'b00;
  localparam logic [1:0] T_DRIVER_DELAY    = 2'b01;
  localparam logic [1:0] T_PASSENGER_DELAY = 2'b10;
  localparam logic [1:0] T_ALARM_ON        = 2'b11;

  localparam int unsigned DefaultClkFreq = 100_000_000;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StCount = 2'b10,
    StDone  = 2'b11
  } timer_state_e;

endpackage

// File: rtl/param_timer_tick_gen.sv
// Free-running prescaler: one-cycle tick every CLK_FREQ enabled cycles.
module tick_gen
  import param_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DefaultClkFreq,
  parameter int unsigned CNT_W    = 27
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [CNT_W-1:0] Term = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt_q;

  // Clear dominates enable so a cleared cycle never produces a tick.
  assign tick = enable && !clear && (cnt_q == Term);

  // Prescaler register: clear, then wrap at terminal count, else increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_timer.sv
// Interval timer: reads a seconds value from the parameter store, counts it
// down at 1 Hz and pulses expired for one cycle when it reaches zero.
module param_timer
  import param_timer_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DefaultClkFreq,
  parameter int unsigned PRESC_W  = 27
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] interval,
  input  logic       abort,
  output logic [1:0] param_sel,
  input  logic [3:0] param_value,
  output logic       busy,
  output logic [3:0] remaining,
  output logic       expired
);

  timer_state_e state_q, state_d;
  logic [1:0]   param_sel_q, param_sel_d;
  logic [3:0]   remaining_q, remaining_d;
  logic         busy_q, expired_q;
  logic         tick, presc_clear, presc_en;

  // Prescaler only runs in COUNT; any abort or restart resets its phase.
  assign presc_en    = (state_q == StCount);
  assign presc_clear = (state_q != StCount) || abort || start_timer;

  tick_gen #(
    .CLK_FREQ (CLK_FREQ),
    .CNT_W    (PRESC_W)
  ) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .clear  (presc_clear),
    .enable (presc_en),
    .tick   (tick)
  );

  // Next-state logic; abort beats start, start beats normal progress.
  always_comb begin
    state_d     = state_q;
    param_sel_d = param_sel_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start_timer && !abort) begin
          param_sel_d = interval;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        if (abort) begin
          remaining_d = '0;
          state_d     = StIdle;
        end else if (start_timer) begin
          param_sel_d = interval;
          remaining_d = '0;
          state_d     = StLoad;
        end else begin
          remaining_d = param_value;
          state_d     = (param_value == 4'd0) ? StDone : StCount;
        end
      end
      StCount: begin
        if (abort) begin
          remaining_d = '0;
          state_d     = StIdle;
        end else if (start_timer) begin
          param_sel_d = interval;
          remaining_d = '0;
          state_d     = StLoad;
        end else if (tick && remaining_q != 4'd0) begin
          remaining_d = remaining_q - 4'd1;
          if (remaining_q == 4'd1) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        remaining_d = '0;
        if (start_timer && !abort) begin
          param_sel_d = interval;
          state_d     = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; outputs are decoded from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      param_sel_q <= '0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      param_sel_q <= param_sel_d;
      remaining_q <= remaining_d;
      busy_q      <= (state_d == StLoad) || (state_d == StCount);
      expired_q   <= (state_d == StDone);
    end
  end

  assign param_sel = param_sel_q;
  assign remaining = remaining_q;
  assign busy      = busy_q;
  assign expired   = expired_q;

endmodule
